tcd_frame_ctrl: RTL and testbench
=================================

Name: tcd_frame_ctrl

Overview:
- Timing generator and ADC sequencer for the TCD1304 linear CCD in the filament sensor.
- Drives the sensor clock (fM), SH and ICG, and triggers one external 12-bit ADC conversion per pixel.
- Delivers a numbered, framed pixel stream with one-cycle valid strobes to downstream analysis: the drop-width/LED logic and any later filament-diameter estimator.
- Its tcd_sh output is the frame marker downstream logic keys on.

Parameters:
- FM_HALF, 12: clk cycles per fM half-period; fM period = 2*FM_HALF; pixel slot = 8*FM_HALF clk (4 fM periods).
- N_PIX, 3694: pixels read out per frame (dummies included).
- ICG_LEAD, 10: clk cycles from ICG falling to SH rising.
- SH_WIDTH, 50: SH high time in clk cycles.
- ICG_TRAIL, 50: minimum clk cycles from SH falling to ICG rising.
- SAMPLE_OFS, 48: clk offset within a pixel slot at which adc_start fires; must satisfy SAMPLE_OFS < 8*FM_HALF (elaboration error otherwise).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run frames continuously while high
- gap_cycles  in  16  idle clk cycles between frame end and next ICG fall; latched at frame_start
- tcd_fm  out  1  sensor master clock
- tcd_sh  out  1  shift gate, active high
- tcd_icg  out  1  integration clear gate, low = transfer
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle pulse, adc_data valid
- adc_data  in  12  conversion result
- pixel_valid  out  1  one-cycle strobe
- pixel_data  out  12  captured sample
- pixel_index  out  12  0..N_PIX-1
- frame_start  out  1  one-cycle pulse on ICG fall
- frame_done  out  1  one-cycle pulse at end of last pixel slot
- overrun  out  1  sticky: a slot ended without adc_done
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: tcd_fm=0, tcd_sh=0, tcd_icg=1; adc_start, pixel_valid, frame_start, frame_done, overrun, busy = 0; pixel_data=0, pixel_index=0; FSM in IDLE.
- Reset mid-frame aborts the frame immediately. No partial frame_done is issued.
- fM is free-running after reset regardless of enable: it toggles when its counter wraps at FM_HALF-1. fm_rise is high for the one cycle in which tcd_fm goes 0->1.
- FSM transitions:
  - IDLE: if enable is high, go to ICG_LEAD. tcd_icg goes 0 and frame_start pulses in the same cycle; gap_cycles is latched and overrun is cleared.
  - ICG_LEAD: after ICG_LEAD cycles, tcd_sh goes 1 and the FSM goes to SH_PULSE.
  - SH_PULSE: after SH_WIDTH cycles, tcd_sh goes 0 and the FSM goes to ICG_TRAIL.
  - ICG_TRAIL: after ICG_TRAIL cycles, wait for the next fm_rise. On that cycle tcd_icg goes 1, slot counter = 0, pixel_index = 0, and the FSM goes to READOUT. Total trail = ICG_TRAIL plus 0..2*FM_HALF-1 alignment cycles.
  - READOUT: the slot counter runs 0..8*FM_HALF-1. adc_start pulses when the slot counter equals SAMPLE_OFS, and the FSM then awaits adc_done.
  - GAP: count latched gap_cycles (0 means a single cycle). Then go to ICG_LEAD if enable is high, else IDLE.
- Pixel output:
  - adc_done while awaiting at cycle t: pixel_data=adc_data and pixel_valid=1 at t+1, with pixel_index equal to the current slot.
  - adc_done while not awaiting (extra or early): ignored.
- Slot end:
  - If still awaiting, set overrun; the pixel is dropped (no pixel_valid) and pixel_index still advances.
  - If adc_done arrives in the same cycle as slot end, it is accepted and overrun is not set.
  - pixel_index increments at each slot end.
- Last slot (N_PIX-1): frame_done pulses in its final cycle and the FSM goes to GAP; pixel_index holds at N_PIX-1.
- enable is sampled only in IDLE and at GAP exit. Deasserting it mid-frame lets the frame complete.
- overrun is cleared only by reset or at frame_start.
- busy = (state != IDLE).

Decomposition:
- Package tcd_pkg: FSM state enum (IDLE, ICG_LEAD, SH_PULSE, ICG_TRAIL, READOUT, GAP), ADC_W=12, IDX_W=12, default timing constants.
- Sub-module tcd_fm_gen: FM_HALF divider producing tcd_fm and the fm_rise strobe.

Test Plan:
Use FM_HALF=2, N_PIX=8, ICG_LEAD=3, SH_WIDTH=4, ICG_TRAIL=5, SAMPLE_OFS=4 (16-clk slot) unless a line states otherwise.
- Reset then enable=1, gap_cycles=10: frame_start pulses with icg fall; SH rises 3 clk later and is high for exactly 4 clk; ICG rises on the first fm_rise at least 5 clk after SH fall; fM period is 4 clk throughout.
- ADC model answers 3 clk after adc_start with data = 100 + index: eight pixel_valid strobes, spaced 16 clk apart, carrying data 100..107 and indices 0..7; frame_done pulses once; next ICG fall occurs 10 clk later.
- ADC model never answers for pixel 3: overrun=1, no strobe for index 3, indices 4..7 still delivered; overrun stays set until the next frame_start, which clears it.
- adc_done coincident with the final slot cycle is accepted with no overrun; a spurious adc_done in GAP produces no pixel_valid.
- enable dropped during READOUT at pixel 2: frame completes through index 7, then FSM returns to IDLE with busy=0, tcd_icg=1, and fM still toggling.
- rst_n asserted during SH_PULSE: outputs go to reset values asynchronously with no frame_done; after release with enable=1, a full clean frame follows.

Source files
------------

// File: rtl/tcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcd_pkg
//  Description : Shared types and constants for the TCD1304 frame controller.
//                Contains the FSM state encoding, bus widths and the default
//                sensor timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package tcd_pkg;

  // Bus widths
  localparam int ADC_W = 12;
  localparam int IDX_W = 12;
  localparam int TMR_W = 16;

  // Default sensor timing, in clk cycles
  localparam int DEF_FM_HALF    = 12;
  localparam int DEF_N_PIX      = 3694;
  localparam int DEF_ICG_LEAD   = 10;
  localparam int DEF_SH_WIDTH   = 50;
  localparam int DEF_ICG_TRAIL  = 50;
  localparam int DEF_SAMPLE_OFS = 48;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ICG_LEAD  = 3'd1,
    ST_SH_PULSE  = 3'd2,
    ST_ICG_TRAIL = 3'd3,
    ST_READOUT   = 3'd4,
    ST_GAP       = 3'd5
  } tcd_state_t;

  // One pixel occupies four fM periods
  function automatic int slot_len(input int fm_half);
    return 8 * fm_half;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcd_fm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tcd_fm_gen
//  Description : Free-running divider for the sensor master clock fM. Toggles
//                tcd_fm every FM_HALF clk cycles and flags the cycle in which
//                tcd_fm is about to go 0->1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcd_fm_gen #(
  parameter int FM_HALF = 12
) (
  input  logic clk,
  input  logic rst_n,
  output logic tcd_fm,
  output logic fm_rise
);

  localparam int CNT_W = (FM_HALF > 1) ? $clog2(FM_HALF) : 1;

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap    = (cnt == CNT_W'(FM_HALF - 1));
  // High in the cycle whose closing edge drives tcd_fm high, so registered
  // logic that acts on it changes on the same edge as fM.
  assign fm_rise = wrap & ~tcd_fm;

  // Half-period counter and fM toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tcd_fm <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      tcd_fm <= ~tcd_fm;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcd_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tcd_frame_ctrl
//  Description : TCD1304 timing generator and ADC sequencer. Produces fM, SH
//                and ICG, requests one conversion per pixel slot and emits a
//                numbered pixel stream with frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcd_frame_ctrl
  import tcd_pkg::*;
#(
  parameter int FM_HALF    = DEF_FM_HALF,
  parameter int N_PIX      = DEF_N_PIX,
  parameter int ICG_LEAD   = DEF_ICG_LEAD,
  parameter int SH_WIDTH   = DEF_SH_WIDTH,
  parameter int ICG_TRAIL  = DEF_ICG_TRAIL,
  parameter int SAMPLE_OFS = DEF_SAMPLE_OFS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      gap_cycles,
  output logic             tcd_fm,
  output logic             tcd_sh,
  output logic             tcd_icg,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             pixel_valid,
  output logic [ADC_W-1:0] pixel_data,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_start,
  output logic             frame_done,
  output logic             overrun,
  output logic             busy
);

  localparam int SLOT_LEN = slot_len(FM_HALF);
  localparam int SLOT_W   = $clog2(SLOT_LEN);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (SAMPLE_OFS < 0 || SAMPLE_OFS >= SLOT_LEN) begin : g_bad_sample_ofs
    $error("tcd_frame_ctrl: SAMPLE_OFS must lie inside the pixel slot");
  end
  if (FM_HALF < 1) begin : g_bad_fm_half
    $error("tcd_frame_ctrl: FM_HALF must be at least 1");
  end
  if (N_PIX < 1 || N_PIX > (1 << IDX_W)) begin : g_bad_n_pix
    $error("tcd_frame_ctrl: N_PIX does not fit the pixel index");
  end
  if (ICG_LEAD < 1 || SH_WIDTH < 1 || ICG_TRAIL < 1 ||
      ICG_LEAD > (1 << TMR_W) || SH_WIDTH > (1 << TMR_W) ||
      ICG_TRAIL > (1 << TMR_W)) begin : g_bad_gate_timing
    $error("tcd_frame_ctrl: gate timing out of range");
  end

  tcd_state_t        state;
  logic [TMR_W-1:0]  timer;
  logic [15:0]       gap_lat;
  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0]  slot_idx;
  logic              awaiting;
  logic              idx_catchup;
  logic              fm_rise;

  logic              slot_end;
  logic              last_pix;
  logic              accept;
  logic              gap_end;
  logic              launch;

  tcd_fm_gen #(
    .FM_HALF (FM_HALF)
  ) u_fm_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .tcd_fm  (tcd_fm),
    .fm_rise (fm_rise)
  );

  assign slot_end = (slot == SLOT_W'(SLOT_LEN - 1));
  assign last_pix = (slot_idx == IDX_W'(N_PIX - 1));
  assign accept   = awaiting & adc_done;
  // A latched gap of zero still spends one cycle in GAP
  assign gap_end  = (gap_lat == 16'd0) || (timer == gap_lat - 16'd1);
  // A frame begins from IDLE or straight out of GAP; both look identical
  assign launch   = enable && ((state == ST_IDLE) || (state == ST_GAP && gap_end));
  assign busy     = (state != ST_IDLE);

  // Frame sequencer with registered sensor, ADC and pixel-stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      gap_lat     <= '0;
      slot        <= '0;
      slot_idx    <= '0;
      awaiting    <= 1'b0;
      idx_catchup <= 1'b0;
      tcd_sh      <= 1'b0;
      tcd_icg     <= 1'b1;
      adc_start   <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      pixel_index <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      adc_start   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      // Index was held for one cycle so a slot-end sample carried its own
      // number; bring it forward to the running slot now.
      if (idx_catchup) begin
        pixel_index <= slot_idx;
        idx_catchup <= 1'b0;
      end

      if (launch) begin
        state       <= ST_ICG_LEAD;
        timer       <= '0;
        tcd_icg     <= 1'b0;
        frame_start <= 1'b1;
        gap_lat     <= gap_cycles;
        overrun     <= 1'b0;
        awaiting    <= 1'b0;
      end else begin
        case (state)
          ST_ICG_LEAD: begin
            if (timer == TMR_W'(ICG_LEAD - 1)) begin
              state  <= ST_SH_PULSE;
              timer  <= '0;
              tcd_sh <= 1'b1;
            end else begin
              timer  <= timer + 1'b1;
            end
          end

          ST_SH_PULSE: begin
            if (timer == TMR_W'(SH_WIDTH - 1)) begin
              state  <= ST_ICG_TRAIL;
              timer  <= '0;
              tcd_sh <= 1'b0;
            end else begin
              timer  <= timer + 1'b1;
            end
          end

          ST_ICG_TRAIL: begin
            // Minimum trail elapsed: hold until fM rises so readout slots
            // stay phase-locked to the sensor clock.
            if (timer >= TMR_W'(ICG_TRAIL - 1)) begin
              if (fm_rise) begin
                state       <= ST_READOUT;
                tcd_icg     <= 1'b1;
                slot        <= '0;
                slot_idx    <= '0;
                pixel_index <= '0;
                idx_catchup <= 1'b0;
                if (SAMPLE_OFS == 0) begin
                  adc_start <= 1'b1;
                  awaiting  <= 1'b1;
                end
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_READOUT: begin
            if (accept) begin
              pixel_valid <= 1'b1;
              pixel_data  <= adc_data;
              awaiting    <= 1'b0;
            end

            if (slot_end) begin
              slot <= '0;
              if (awaiting && !adc_done) begin
                overrun  <= 1'b1;
                awaiting <= 1'b0;
              end
              if (last_pix) begin
                state <= ST_GAP;
                timer <= '0;
              end else begin
                slot_idx <= slot_idx + 1'b1;
                if (accept) begin
                  idx_catchup <= 1'b1;
                end else begin
                  pixel_index <= slot_idx + 1'b1;
                end
                if (SAMPLE_OFS == 0) begin
                  adc_start <= 1'b1;
                  awaiting  <= 1'b1;
                end
              end
            end else begin
              slot       <= slot + 1'b1;
              frame_done <= last_pix && (slot == SLOT_W'(SLOT_LEN - 2));
              if (SAMPLE_OFS != 0 && slot == SLOT_W'(SAMPLE_OFS - 1)) begin
                adc_start <= 1'b1;
                awaiting  <= 1'b1;
              end
            end
          end

          ST_GAP: begin
            // launch covers the enabled exit; here only the stop path
            if (gap_end) begin
              state <= ST_IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcd_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcd_frame_ctrl
//  Description : Directed self-checking bench for tcd_frame_ctrl with a small
//                behavioural ADC (programmable latency, skippable pixel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcd_frame_ctrl;

  localparam int FM_HALF    = 2;
  localparam int N_PIX      = 8;
  localparam int ICG_LEAD   = 3;
  localparam int SH_WIDTH   = 4;
  localparam int ICG_TRAIL  = 5;
  localparam int SAMPLE_OFS = 4;
  localparam int SLOT       = 8 * FM_HALF;
  localparam int GAP        = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] gap_cycles;
  logic        tcd_fm, tcd_sh, tcd_icg, adc_start;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        pixel_valid;
  logic [11:0] pixel_data, pixel_index;
  logic        frame_start, frame_done, overrun, busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // ADC model controls (written by the main sequence only)
  int adc_lat  = 3;
  int skip_idx = -1;
  int spur_req = 0;

  // Frame observation results
  int fs_cyc, icg_fall_cyc, sh_rise_cyc, sh_fall_cyc, icg_rise_cyc;
  int icg_al, fm_bad, fd_cnt, fd_cyc, pv_n, prev_fd;
  int ov_before, ov_at_fs, ov_end;
  int pv_dat [16];
  int pv_idx [16];
  int pv_cyc [16];

  tcd_frame_ctrl #(
    .FM_HALF    (FM_HALF),
    .N_PIX      (N_PIX),
    .ICG_LEAD   (ICG_LEAD),
    .SH_WIDTH   (SH_WIDTH),
    .ICG_TRAIL  (ICG_TRAIL),
    .SAMPLE_OFS (SAMPLE_OFS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .gap_cycles  (gap_cycles),
    .tcd_fm      (tcd_fm),
    .tcd_sh      (tcd_sh),
    .tcd_icg     (tcd_icg),
    .adc_start   (adc_start),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural ADC: answers adc_lat cycles after adc_start with 100+n, where
  // n counts conversions since frame_start; can skip one pixel or inject a
  // stray adc_done on request.
  initial begin : adc_model
    int cnt;
    int my;
    int spur_ack;
    cnt      = 0;
    spur_ack = 0;
    adc_done = 1'b0;
    adc_data = 12'd0;
    forever begin
      @(negedge clk);
      if (frame_start) cnt = 0;
      if (adc_start) begin
        my  = cnt;
        cnt = cnt + 1;
        if (my != skip_idx) begin
          repeat (adc_lat) @(posedge clk);
          #1;
          adc_data = 12'(100 + my);
          adc_done = 1'b1;
          @(posedge clk);
          #1 adc_done = 1'b0;
        end
      end else if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        @(posedge clk);
        #1;
        adc_data = 12'hABC;
        adc_done = 1'b1;
        @(posedge clk);
        #1 adc_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample every cycle on the falling edge until frame_done (plus one cycle)
  task automatic watch_frame(input int drop_idx);
    logic pfm, psh, picg, pov;
    int   last_rise;
    fs_cyc = -1; icg_fall_cyc = -1; sh_rise_cyc = -1; sh_fall_cyc = -1;
    icg_rise_cyc = -1; icg_al = 0; fm_bad = 0; fd_cnt = 0; fd_cyc = -1;
    pv_n = 0; ov_before = -1; ov_at_fs = -1; ov_end = -1; last_rise = -1;
    pfm = tcd_fm; psh = tcd_sh; picg = tcd_icg; pov = overrun;
    for (int n = 0; n < 400 && fd_cnt == 0; n++) begin
      @(negedge clk);
      if (tcd_fm && !pfm) begin
        if (last_rise >= 0 && cyc - last_rise != 2 * FM_HALF) fm_bad++;
        last_rise = cyc;
      end
      if (frame_start && fs_cyc < 0) begin
        fs_cyc = cyc; ov_before = int'(pov); ov_at_fs = int'(overrun);
      end
      if (!tcd_icg && picg) icg_fall_cyc = cyc;
      if (tcd_sh && !psh)   sh_rise_cyc = cyc;
      if (!tcd_sh && psh)   sh_fall_cyc = cyc;
      if (tcd_icg && !picg) begin
        icg_rise_cyc = cyc;
        icg_al = (tcd_fm && !pfm) ? 1 : 0;
      end
      if (pixel_valid && pv_n < 16) begin
        pv_dat[pv_n] = int'(pixel_data);
        pv_idx[pv_n] = int'(pixel_index);
        pv_cyc[pv_n] = cyc;
        pv_n++;
        if (int'(pixel_index) == drop_idx) enable = 1'b0;
      end
      if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
      pfm = tcd_fm; psh = tcd_sh; picg = tcd_icg; pov = overrun;
    end
    if (fd_cnt == 0) chk("frame_timeout", 0, 1);
    @(negedge clk);
    if (pixel_valid && pv_n < 16) begin
      pv_dat[pv_n] = int'(pixel_data);
      pv_idx[pv_n] = int'(pixel_index);
      pv_cyc[pv_n] = cyc;
      pv_n++;
    end
    if (frame_done) fd_cnt++;
    ov_end = int'(overrun);
  endtask

  // Pixel stream against the expected indices, data, spacing and latency
  task automatic check_pixels(input int skip, input int first_ofs);
    int exp_n, ei, pe;
    exp_n = (skip >= 0) ? N_PIX - 1 : N_PIX;
    chk("pv_count", pv_n, exp_n);
    pe = -1;
    for (int k = 0; k < pv_n && k < exp_n; k++) begin
      ei = (skip >= 0 && k >= skip) ? k + 1 : k;
      chk("pv_index", pv_idx[k], ei);
      chk("pv_data", pv_dat[k], 100 + ei);
      if (k > 0) chk("pv_spacing", pv_cyc[k] - pv_cyc[k-1], SLOT * (ei - pe));
      pe = ei;
    end
    if (pv_n > 0) chk("pv_first_ofs", pv_cyc[0] - icg_rise_cyc, first_ofs);
    chk("fd_count", fd_cnt, 1);
    chk("fd_position", fd_cyc - icg_rise_cyc, N_PIX * SLOT - 1);
  endtask

  initial begin : main
    int cnt, tog;
    logic pfm;
    rst_n      = 1'b0;
    enable     = 1'b0;
    gap_cycles = 16'(GAP);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_fm", tcd_fm, 0);
    chk("rst_sh", tcd_sh, 0);
    chk("rst_icg", tcd_icg, 1);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pixel_data", pixel_data, 0);
    chk("rst_pixel_index", pixel_index, 0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Frame 1: gate timing and clean readout
    enable = 1'b1;
    watch_frame(-1);
    chk("f1_icg_fall_with_fs", icg_fall_cyc - fs_cyc, 0);
    chk("f1_sh_lead", sh_rise_cyc - icg_fall_cyc, ICG_LEAD);
    chk("f1_sh_width", sh_fall_cyc - sh_rise_cyc, SH_WIDTH);
    chk("f1_trail_range", (icg_rise_cyc - sh_fall_cyc >= ICG_TRAIL) &&
                          (icg_rise_cyc - sh_fall_cyc <= ICG_TRAIL + 2 * FM_HALF - 1), 1);
    chk("f1_icg_on_fm_rise", icg_al, 1);
    chk("f1_fm_period", fm_bad, 0);
    check_pixels(-1, SAMPLE_OFS + 3 + 1);
    chk("f1_overrun", ov_end, 0);
    prev_fd = fd_cyc;

    // Frame 2: pixel 3 never converted
    skip_idx = 3;
    watch_frame(-1);
    chk("f2_gap", fs_cyc - prev_fd, GAP + 1);
    check_pixels(3, SAMPLE_OFS + 3 + 1);
    chk("f2_overrun", ov_end, 1);
    prev_fd = fd_cyc;
    skip_idx = -1;
    @(negedge clk);
    chk("f2_overrun_sticky", overrun, 1);

    // Frame 3: every answer lands in the final slot cycle
    adc_lat = SLOT - 1 - SAMPLE_OFS;
    watch_frame(-1);
    chk("f3_gap", fs_cyc - prev_fd, GAP + 1);
    chk("f3_overrun_before_fs", ov_before, 1);
    chk("f3_overrun_clear_at_fs", ov_at_fs, 0);
    check_pixels(-1, SLOT);
    chk("f3_overrun", ov_end, 0);
    prev_fd = fd_cyc;

    // Stray adc_done during GAP
    adc_lat = 3;
    spur_req++;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (pixel_valid) cnt++;
    end
    chk("gap_spurious_valid", cnt, 0);
    chk("gap_busy", busy, 1);

    // Frame 4: enable dropped once pixel 2 is delivered
    watch_frame(2);
    chk("f4_gap", fs_cyc - prev_fd, GAP + 1);
    check_pixels(-1, SAMPLE_OFS + 3 + 1);
    cnt = 0;
    tog = 0;
    pfm = tcd_fm;
    repeat (20) begin
      @(negedge clk);
      if (frame_start) cnt++;
      if (tcd_fm != pfm) tog++;
      pfm = tcd_fm;
    end
    chk("f4_no_restart", cnt, 0);
    chk("f4_idle_busy", busy, 0);
    chk("f4_idle_icg", tcd_icg, 1);
    chk("f4_fm_toggles", tog, 20 / FM_HALF);

    // Asynchronous reset during SH_PULSE
    enable = 1'b1;
    cnt = 0;
    while (!tcd_sh && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_reached_sh", tcd_sh, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_sh", tcd_sh, 0);
    chk("arst_icg", tcd_icg, 1);
    chk("arst_busy", busy, 0);
    chk("arst_fm", tcd_fm, 0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done) cnt++;
    end
    chk("arst_no_frame_done", cnt, 0);
    rst_n = 1'b1;
    watch_frame(-1);
    chk("f5_sh_width", sh_fall_cyc - sh_rise_cyc, SH_WIDTH);
    check_pixels(-1, SAMPLE_OFS + 3 + 1);
    chk("f5_overrun", ov_end, 0);

    enable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
